// File: rtl/debug_mode_ctrl.sv
// Debugger top-level sequencer: decodes UART command bytes, launches one mode FSM,
// waits for it to finish (or for a load timeout) and answers with an ACK byte.
module debug_mode_ctrl #(
  parameter logic [7:0]  CMD_LOAD     = 8'h01,
  parameter logic [7:0]  CMD_CONT     = 8'h02,
  parameter logic [7:0]  CMD_STEP     = 8'h03,
  parameter logic [7:0]  ACK_OK       = 8'hAA,
  parameter logic [7:0]  ACK_ERR      = 8'hEE,
  parameter int unsigned LOAD_TIMEOUT = 1_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] i_rx_data,
  input  logic       is_rx_done,
  input  logic       is_done_load,
  input  logic       is_done_cont,
  input  logic       is_done_step,
  input  logic       is_tx_done,
  output logic       os_start_load,
  output logic       os_start_cont,
  output logic       os_start_step,
  output logic       os_abort,
  output logic       os_tx_start,
  output logic [7:0] o_tx_data,
  output logic [1:0] o_mode,
  output logic       os_busy
);

  localparam int unsigned CNT_W = ($clog2(LOAD_TIMEOUT) > 0) ? $clog2(LOAD_TIMEOUT) : 1;

  localparam logic [1:0] MODE_NONE = 2'b00;
  localparam logic [1:0] MODE_LOAD = 2'b01;
  localparam logic [1:0] MODE_CONT = 2'b10;
  localparam logic [1:0] MODE_STEP = 2'b11;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    START    = 3'd1,
    RUN      = 3'd2,
    ACK_SEND = 3'd3,
    ACK_WAIT = 3'd4
  } state_t;

  state_t           state, state_next;
  logic [1:0]       kind, kind_next;
  logic [7:0]       ack_byte, ack_next;
  logic [CNT_W-1:0] cnt, cnt_next;

  logic       start_load_next, start_cont_next, start_step_next;
  logic       abort_next, tx_start_next, busy_next;
  logic [7:0] tx_data_next;
  logic [1:0] mode_next;
  logic       done_active;

  // State, bookkeeping and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      kind          <= MODE_NONE;
      ack_byte      <= 8'h00;
      cnt           <= '0;
      os_start_load <= 1'b0;
      os_start_cont <= 1'b0;
      os_start_step <= 1'b0;
      os_abort      <= 1'b0;
      os_tx_start   <= 1'b0;
      o_tx_data     <= 8'h00;
      o_mode        <= MODE_NONE;
      os_busy       <= 1'b0;
    end else begin
      state         <= state_next;
      kind          <= kind_next;
      ack_byte      <= ack_next;
      cnt           <= cnt_next;
      os_start_load <= start_load_next;
      os_start_cont <= start_cont_next;
      os_start_step <= start_step_next;
      os_abort      <= abort_next;
      os_tx_start   <= tx_start_next;
      o_tx_data     <= tx_data_next;
      o_mode        <= mode_next;
      os_busy       <= busy_next;
    end
  end

  // Only the done pulse of the launched mode can end RUN
  always_comb begin
    unique case (kind)
      MODE_LOAD: done_active = is_done_load;
      MODE_CONT: done_active = is_done_cont;
      MODE_STEP: done_active = is_done_step;
      default:   done_active = 1'b0;
    endcase
  end

  // Next-state and next-output logic
  always_comb begin
    state_next      = state;
    kind_next       = kind;
    ack_next        = ack_byte;
    cnt_next        = cnt;
    start_load_next = 1'b0;
    start_cont_next = 1'b0;
    start_step_next = 1'b0;
    abort_next      = 1'b0;
    tx_start_next   = 1'b0;
    tx_data_next    = o_tx_data;
    mode_next       = o_mode;

    case (state)
      IDLE: begin
        if (is_rx_done) begin
          if (i_rx_data == CMD_LOAD) begin
            kind_next  = MODE_LOAD;
            state_next = START;
          end else if (i_rx_data == CMD_CONT) begin
            kind_next  = MODE_CONT;
            state_next = START;
          end else if (i_rx_data == CMD_STEP) begin
            kind_next  = MODE_STEP;
            state_next = START;
          end else begin
            ack_next   = ACK_ERR;
            state_next = ACK_SEND;
          end
        end
      end
      START: begin
        start_load_next = (kind == MODE_LOAD);
        start_cont_next = (kind == MODE_CONT);
        start_step_next = (kind == MODE_STEP);
        mode_next       = kind;
        cnt_next        = '0;
        state_next      = RUN;
      end
      RUN: begin
        if (done_active) begin
          mode_next  = MODE_NONE;
          ack_next   = ACK_OK;
          state_next = ACK_SEND;
        end else if (kind == MODE_LOAD) begin
          // Idle watchdog between program bytes
          if (is_rx_done) begin
            cnt_next = '0;
          end else if (cnt == CNT_W'(LOAD_TIMEOUT - 1)) begin
            abort_next = 1'b1;
            mode_next  = MODE_NONE;
            ack_next   = ACK_ERR;
            state_next = ACK_SEND;
          end else begin
            cnt_next = cnt + CNT_W'(1);
          end
        end
      end
      ACK_SEND: begin
        tx_start_next = 1'b1;
        tx_data_next  = ack_byte;
        state_next    = ACK_WAIT;
      end
      ACK_WAIT: begin
        if (is_tx_done) state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
        mode_next  = MODE_NONE;
      end
    endcase

    busy_next = (state_next != IDLE);
  end

endmodule

// File: tb/tb_debug_mode_ctrl.sv
// Directed bench for debug_mode_ctrl: a timestamp-based transaction model is compared
// against the DUT every cycle, plus literal checks on key cycles.
module tb_debug_mode_ctrl;

  localparam int unsigned T = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] i_rx_data = 8'h00;
  logic       is_rx_done = 1'b0;
  logic       is_done_load = 1'b0;
  logic       is_done_cont = 1'b0;
  logic       is_done_step = 1'b0;
  logic       is_tx_done = 1'b0;
  logic       os_start_load, os_start_cont, os_start_step, os_abort, os_tx_start, os_busy;
  logic [7:0] o_tx_data;
  logic [1:0] o_mode;

  debug_mode_ctrl #(.LOAD_TIMEOUT(T)) dut (
    .clk(clk), .rst(rst), .i_rx_data(i_rx_data), .is_rx_done(is_rx_done),
    .is_done_load(is_done_load), .is_done_cont(is_done_cont), .is_done_step(is_done_step),
    .is_tx_done(is_tx_done), .os_start_load(os_start_load), .os_start_cont(os_start_cont),
    .os_start_step(os_start_step), .os_abort(os_abort), .os_tx_start(os_tx_start),
    .o_tx_data(o_tx_data), .o_mode(o_mode), .os_busy(os_busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  // Transaction model: phase 0 = waiting for a command, 1 = mode launched, 2 = acknowledging.
  // Events are stored as the absolute cycle at which the resulting output pulse must appear.
  bit chk_en   = 0;
  int phase    = 0;
  int kind     = 0;
  int start_at = -1;
  int abort_at = -1;
  int tx_at    = -1;
  int last_rx  = 0;
  int pend     = 0;
  int exp_mode = 0;
  int exp_busy = 0;
  int exp_data = 0;

  always @(posedge clk) begin
    int c;
    bit done;
    c = cyc;
    if (rst) begin
      chk_en = 1; phase = 0; start_at = -1; abort_at = -1; tx_at = -1;
      exp_mode = 0; exp_busy = 0; exp_data = 0;
    end else begin
      if (tx_at == c + 1) exp_data = pend;
      if (start_at == c + 1) exp_mode = kind;
      case (phase)
        0: if (is_rx_done) begin
          exp_busy = 1;
          if (int'(i_rx_data) >= 1 && int'(i_rx_data) <= 3) begin
            kind = int'(i_rx_data); start_at = c + 2; last_rx = c + 2; phase = 1;
          end else begin
            tx_at = c + 2; pend = 'hEE; phase = 2;
          end
        end
        1: if (c >= start_at) begin
          done = (kind == 1) ? is_done_load : (kind == 2) ? is_done_cont : is_done_step;
          if (done) begin
            exp_mode = 0; tx_at = c + 2; pend = 'hAA; phase = 2;
          end else if (kind == 1) begin
            if (is_rx_done) last_rx = c + 1;
            else if (c - last_rx == int'(T) - 1) begin
              abort_at = c + 1; tx_at = c + 2; pend = 'hEE; exp_mode = 0; phase = 2;
            end
          end
        end
        default: if (c >= tx_at && is_tx_done) begin
          phase = 0; exp_busy = 0;
        end
      endcase
    end
    cyc++;
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (chk_en) begin
      chk("start_load", int'(os_start_load), int'(cyc == start_at && kind == 1));
      chk("start_cont", int'(os_start_cont), int'(cyc == start_at && kind == 2));
      chk("start_step", int'(os_start_step), int'(cyc == start_at && kind == 3));
      chk("abort",      int'(os_abort),      int'(cyc == abort_at));
      chk("tx_start",   int'(os_tx_start),   int'(cyc == tx_at));
      chk("tx_data",    int'(o_tx_data),     exp_data);
      chk("mode",       int'(o_mode),        exp_mode);
      chk("busy",       int'(os_busy),       exp_busy);
    end
  end

  task automatic drv(input logic r, input logic rx, input logic [7:0] d,
                     input logic dl, input logic dc, input logic ds, input logic td);
    @(posedge clk); #1;
    rst = r; is_rx_done = rx; i_rx_data = d;
    is_done_load = dl; is_done_cont = dc; is_done_step = ds; is_tx_done = td;
  endtask

  task automatic nop(input int n);
    repeat (n) drv(0, 0, 8'h00, 0, 0, 0, 0);
  endtask

  task automatic cmd(input logic [7:0] d);
    drv(0, 1, d, 0, 0, 0, 0);
  endtask

  task automatic finish_ack();
    drv(0, 0, 8'h00, 0, 0, 0, 1);
    nop(2);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    drv(1, 0, 8'h00, 0, 0, 0, 0);
    drv(1, 0, 8'h00, 0, 0, 0, 0);
    nop(1); @(negedge clk);
    chk("reset_mode", int'(o_mode), 0);
    chk("reset_busy", int'(os_busy), 0);
    chk("reset_data", int'(o_tx_data), 0);

    // Step command, then step done
    cmd(8'h03);
    nop(1); @(negedge clk);
    chk("t1_busy_n1", int'(os_busy), 1);
    chk("t1_start_n1", int'(os_start_step), 0);
    nop(1); @(negedge clk);
    chk("t1_start_n2", int'(os_start_step), 1);
    chk("t1_mode", int'(o_mode), 3);
    nop(3);
    drv(0, 0, 8'h00, 0, 0, 1, 0);
    nop(1); @(negedge clk);
    chk("t1_mode_clr", int'(o_mode), 0);
    nop(1); @(negedge clk);
    chk("t1_tx", int'(os_tx_start), 1);
    chk("t1_ack", int'(o_tx_data), 'hAA);
    drv(0, 0, 8'h00, 0, 0, 0, 1);
    nop(1); @(negedge clk);
    chk("t1_idle", int'(os_busy), 0);

    // Unknown command
    cmd(8'h55);
    nop(2); @(negedge clk);
    chk("t2_tx", int'(os_tx_start), 1);
    chk("t2_err", int'(o_tx_data), 'hEE);
    finish_ack();
    @(negedge clk);
    chk("t2_idle", int'(os_busy), 0);

    // Load timeout with no bytes
    cmd(8'h01);
    nop(2); @(negedge clk);
    chk("t3_start", int'(os_start_load), 1);
    nop(15); @(negedge clk);
    chk("t3_no_abort_yet", int'(os_abort), 0);
    nop(1); @(negedge clk);
    chk("t3_abort", int'(os_abort), 1);
    nop(1); @(negedge clk);
    chk("t3_tx", int'(os_tx_start), 1);
    chk("t3_err", int'(o_tx_data), 'hEE);
    finish_ack();

    // Load with bytes every 10 cycles, then done
    cmd(8'h01);
    nop(2);
    for (int i = 0; i < 5; i++) begin
      nop(9);
      drv(0, 1, 8'(8'h10 + i), 0, 0, 0, 0);
    end
    nop(3);
    drv(0, 0, 8'h00, 1, 0, 0, 0);
    nop(1);
    nop(1); @(negedge clk);
    chk("t4_tx", int'(os_tx_start), 1);
    chk("t4_ok", int'(o_tx_data), 'hAA);
    finish_ack();

    // Done and timeout on the same cycle: done wins
    cmd(8'h01);
    nop(2);
    nop(14);
    drv(0, 0, 8'h00, 1, 0, 0, 0);
    nop(1); @(negedge clk);
    chk("tb_no_abort", int'(os_abort), 0);
    nop(1); @(negedge clk);
    chk("tb_ok", int'(o_tx_data), 'hAA);
    finish_ack();

    // Continuous mode ignores foreign done pulses and rx bytes
    cmd(8'h02);
    nop(3);
    drv(0, 0, 8'h00, 0, 0, 1, 0);
    cmd(8'h01);
    drv(0, 0, 8'h00, 1, 0, 0, 0);
    nop(2); @(negedge clk);
    chk("t5_mode", int'(o_mode), 2);
    chk("t5_busy", int'(os_busy), 1);
    drv(0, 0, 8'h00, 0, 1, 0, 0);
    nop(1);
    nop(1); @(negedge clk);
    chk("t5_ok", int'(o_tx_data), 'hAA);
    cmd(8'h03);
    finish_ack();
    @(negedge clk);
    chk("t5_dropped", int'(os_busy), 0);

    // Reset during ACK_WAIT, then a fresh command
    cmd(8'h55);
    nop(2);
    nop(1);
    drv(1, 0, 8'h00, 0, 0, 0, 0);
    nop(1); @(negedge clk);
    chk("t6_busy", int'(os_busy), 0);
    chk("t6_data", int'(o_tx_data), 0);
    chk("t6_mode", int'(o_mode), 0);
    cmd(8'h02);
    nop(2); @(negedge clk);
    chk("t6_start", int'(os_start_cont), 1);
    chk("t6_mode2", int'(o_mode), 2);
    drv(0, 0, 8'h00, 0, 1, 0, 0);
    nop(2);
    finish_ack();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
